change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Downstream of the vending next-state logic: accepts a change/refund amount
//  and drives the coin ejectors one coin at a time, greedy high-value first.
//  Each coin is a timed solenoid pulse followed by a recovery gap, both timed
//  in ticks of a slow enable strobe from the clock divider. busy/remaining
//  feed the seven-segment display; done tells the NSL the payout has finished.
// PARAMETERS
//  CHG_W        4    width of change amount / remaining
//  HI_VALUE     5    value of the high coin; low coin value is fixed at 1
//  PULSE_TICKS  100  ticks coin output held high (>=1)
//  GAP_TICKS    100  ticks of idle gap after each coin (>=1)
//  CNT_W        8    tick counter width; must hold max(PULSE_TICKS,GAP_TICKS)-1
// PORTS
//  clk           in   1      system clock; only clock
//  rst           in   1      asynchronous, active-high reset
//  tick          in   1      1-cycle enable strobe; the only timebase for pulse/gap
//  change_valid  in   1      change amount offered
//  change        in   CHG_W  amount to pay out; sampled on accept
//  change_ready  out  1      high only in IDLE; accept = change_valid & change_ready
//  coin_hi       out  1      high-coin ejector drive
//  coin_lo       out  1      low-coin ejector drive
//  busy          out  1      high in every state except IDLE
//  remaining     out  CHG_W  amount still owed; drops when each pulse completes
//  done          out  1      1-cycle strobe at end of payout
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, coin_hi=coin_lo=0, busy=0, done=0,
//   remaining=0, tick counter=0; change_ready=1 once rst deasserts.
//  All outputs registered (change_ready decoded from state register).
//  FSM: IDLE, SELECT, PULSE, GAP, DONE.
//  IDLE: on accept with change!=0: remaining<=change, ->SELECT.
//   On accept with change==0: ->DONE (no coins). No accept: stay.
//  SELECT (1 cycle): remaining>=HI_VALUE selects hi coin, else lo coin;
//   counter<=0, ->PULSE. Selected output rises on entering PULSE
//   (coin output high 2 cycles after the accept edge).
//  PULSE: exactly one of coin_hi/coin_lo high; counter increments on tick only.
//   On tick with counter==PULSE_TICKS-1: coin output low, remaining -= coin
//   value, counter<=0, ->GAP.
//  GAP: both coins low; on tick with counter==GAP_TICKS-1: ->DONE if
//   remaining==0, else ->SELECT.
//  DONE: done=1 for exactly one cycle, busy=0 next cycle, ->IDLE.
//  Boundaries: change_valid while not IDLE ignored (not queued); remaining
//   never underflows (lo coin only selected when remaining<HI_VALUE, and only
//   while remaining>0); tick during SELECT/DONE/IDLE has no effect; tick held
//   high continuously = one count per cycle; reset mid-PULSE drops the coin
//   output asynchronously and the partially paid amount is discarded.
//  coin_hi and coin_lo are never high simultaneously.
// TESTING (PULSE_TICKS=2, GAP_TICKS=1, HI_VALUE=5 unless stated)
//  1 tick=1, change=7 accepted -> coin_hi high 2 cycles, then two coin_lo
//    pulses of 2 cycles each, 1-cycle gaps; remaining 7->2->1->0; one done.
//  2 change=0 accepted -> no coin pulse, done high 2 cycles after accept edge.
//  3 change=5 -> exactly one coin_hi pulse, zero coin_lo, remaining 5->0.
//  4 change_valid=1 with change=3 during a payout -> change_ready=0, ignored;
//    remaining tracks the original amount only.
//  5 rst asserted mid-PULSE -> coin outputs, busy, remaining go 0 without a
//    clock edge; after release change_ready=1 and a new change=1 pays 1 coin.
//  6 tick every 4th cycle, change=1 -> coin_lo high for 8 cycles, gap 4 cycles.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time, high-value
// coin first. Each coin is a solenoid pulse followed by a recovery gap, both
// counted in ticks of a slow enable strobe. All outputs are registered.
//
// Timing, counted from the clock edge that accepts an amount:
//  - the selected coin output rises on the second edge;
//  - done is registered from the DONE state, so for a zero amount it also
//    rises on the second edge.
module change_dispenser #(
  parameter int CHG_W       = 4,
  parameter int HI_VALUE    = 5,
  parameter int PULSE_TICKS = 100,
  parameter int GAP_TICKS   = 100,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             change_valid,
  input  logic [CHG_W-1:0] change,
  output logic             change_ready,
  output logic             coin_hi,
  output logic             coin_lo,
  output logic             busy,
  output logic [CHG_W-1:0] remaining,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);
  localparam logic [CHG_W-1:0] HI_AMT     = CHG_W'(HI_VALUE);
  localparam logic [CHG_W-1:0] LO_AMT     = CHG_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CHG_W-1:0] remaining_nxt;
  logic             coin_hi_nxt;
  logic             coin_lo_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             accept;

  assign change_ready = (state == IDLE);
  assign accept       = change_valid & change_ready;

  // Next-state, tick counting, coin selection and payout bookkeeping
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    remaining_nxt = remaining;
    coin_hi_nxt   = coin_hi;
    coin_lo_nxt   = coin_lo;

    case (state)
      IDLE: begin
        if (accept) begin
          if (change != '0) begin
            remaining_nxt = change;
            state_nxt     = SELECT;
          end else begin
            state_nxt = DONE;
          end
        end
      end

      SELECT: begin
        count_nxt = '0;
        state_nxt = PULSE;
        if (remaining >= HI_AMT) begin
          coin_hi_nxt = 1'b1;
        end else begin
          coin_lo_nxt = 1'b1;
        end
      end

      PULSE: begin
        if (tick) begin
          if (count == PULSE_LAST) begin
            coin_hi_nxt   = 1'b0;
            coin_lo_nxt   = 1'b0;
            remaining_nxt = remaining - (coin_hi ? HI_AMT : LO_AMT);
            count_nxt     = '0;
            state_nxt     = GAP;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end

      GAP: begin
        if (tick) begin
          if (count == GAP_LAST) begin
            count_nxt = '0;
            state_nxt = (remaining == '0) ? DONE : SELECT;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt   = IDLE;
        coin_hi_nxt = 1'b0;
        coin_lo_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == DONE);
  end

  // Registered state and outputs; reset drops the coin drives immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      remaining <= '0;
      coin_hi   <= 1'b0;
      coin_lo   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      remaining <= remaining_nxt;
      coin_hi   <= coin_hi_nxt;
      coin_lo   <= coin_lo_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed test of change_dispenser with PULSE_TICKS=2,
// GAP_TICKS=1, HI_VALUE=5. Expected values are hand-derived per cycle,
// indexed by k = number of clock edges since the accepting edge.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       change_valid;
  logic [3:0] change;
  logic       change_ready;
  logic       coin_hi;
  logic       coin_lo;
  logic       busy;
  logic [3:0] remaining;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  logic [14:0] t1_hi;
  logic [14:0] t1_lo;
  logic [14:0] t1_busy;
  logic [14:0] t1_done;
  int          t1_rem[15];

  change_dispenser #(
    .CHG_W      (4),
    .HI_VALUE   (5),
    .PULSE_TICKS(2),
    .GAP_TICKS  (1),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .change_valid(change_valid),
    .change      (change),
    .change_ready(change_ready),
    .coin_hi     (coin_hi),
    .coin_lo     (coin_lo),
    .busy        (busy),
    .remaining   (remaining),
    .done        (done)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Single comparison point: counts the vector, reports a miscompare
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compares every output against one expected cycle snapshot
  task automatic check_all(input string tag, input int k, input logic e_hi,
                           input logic e_lo, input logic [3:0] e_rem,
                           input logic e_busy, input logic e_done);
    check_output($sformatf("%s coin_hi k=%0d", tag, k), 32'(coin_hi), 32'(e_hi));
    check_output($sformatf("%s coin_lo k=%0d", tag, k), 32'(coin_lo), 32'(e_lo));
    check_output($sformatf("%s remaining k=%0d", tag, k), 32'(remaining), 32'(e_rem));
    check_output($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(e_busy));
    check_output($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(e_done));
    check_output($sformatf("%s change_ready k=%0d", tag, k), 32'(change_ready),
                 32'(!e_busy));
  endtask

  // Advance one clock edge and settle just after it
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Offers an amount for one edge; returns just after that accepting edge
  task automatic apply_stimulus(input logic [3:0] amount);
    change_valid = 1'b1;
    change       = amount;
    next_cycle();
    change_valid = 1'b0;
    change       = '0;
  endtask

  // Directed sequence
  initial begin
    rst          = 1'b1;
    tick         = 1'b1;
    change_valid = 1'b0;
    change       = '0;

    t1_hi   = 15'h0006;
    t1_lo   = 15'h0660;
    t1_busy = 15'h1FFF;
    t1_done = 15'h2000;
    t1_rem  = '{7, 7, 7, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0};

    // Reset state before any clock edge
    #2;
    check_output("reset coin_hi", 32'(coin_hi), 32'd0);
    check_output("reset coin_lo", 32'(coin_lo), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset done", 32'(done), 32'd0);
    check_output("reset remaining", 32'(remaining), 32'd0);
    #10;
    rst = 1'b0;
    next_cycle();
    check_output("post-reset change_ready", 32'(change_ready), 32'd1);
    check_output("post-reset busy", 32'(busy), 32'd0);

    // 1: change=7 -> one hi coin, two lo coins
    $display("[TB] test 1: change=7");
    apply_stimulus(4'd7);
    for (int k = 0; k < 15; k++) begin
      if (k > 0) next_cycle();
      check_all("t1", k, t1_hi[k], t1_lo[k], 4'(t1_rem[k]), t1_busy[k], t1_done[k]);
    end
    next_cycle();

    // 2: change=0 -> no coins, done on the second edge
    $display("[TB] test 2: change=0");
    apply_stimulus(4'd0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      check_all("t2", k, 1'b0, 1'b0, 4'd0, (k == 0), (k == 1));
    end
    next_cycle();

    // 3: change=5 -> exactly one hi coin
    $display("[TB] test 3: change=5");
    apply_stimulus(4'd5);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) next_cycle();
      check_all("t3", k, (k == 1 || k == 2), 1'b0, (k < 3) ? 4'd5 : 4'd0,
                (k <= 4), (k == 5));
    end
    next_cycle();

    // 4: change=6 with a competing request held during the payout
    $display("[TB] test 4: request during payout");
    apply_stimulus(4'd6);
    check_all("t4", 0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
    change_valid = 1'b1;
    change       = 4'd3;
    for (int k = 1; k < 11; k++) begin
      next_cycle();
      check_all("t4", k, (k == 1 || k == 2), (k == 5 || k == 6),
                (k < 3) ? 4'd6 : ((k < 7) ? 4'd1 : 4'd0), (k <= 8), (k == 9));
      if (k == 7) begin
        change_valid = 1'b0;
        change       = '0;
      end
    end
    next_cycle();

    // 5: reset mid-pulse, then a fresh single-coin payout
    $display("[TB] test 5: reset mid-pulse");
    apply_stimulus(4'd7);
    next_cycle();
    check_output("t5 coin_hi before reset", 32'(coin_hi), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_output("t5 coin_hi in reset", 32'(coin_hi), 32'd0);
    check_output("t5 coin_lo in reset", 32'(coin_lo), 32'd0);
    check_output("t5 busy in reset", 32'(busy), 32'd0);
    check_output("t5 remaining in reset", 32'(remaining), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    next_cycle();
    check_output("t5 change_ready after release", 32'(change_ready), 32'd1);
    check_output("t5 remaining after release", 32'(remaining), 32'd0);
    apply_stimulus(4'd1);
    for (int k = 1; k < 7; k++) begin
      next_cycle();
      check_all("t5", k, 1'b0, (k == 1 || k == 2), (k < 3) ? 4'd1 : 4'd0,
                (k <= 4), (k == 5));
    end
    next_cycle();

    // 6: tick every 4th cycle (one tick lands in SELECT and is ignored)
    $display("[TB] test 6: slow tick");
    tick = 1'b0;
    apply_stimulus(4'd1);
    for (int k = 1; k < 16; k++) begin
      tick = ((k % 4) == 1);
      next_cycle();
      check_all("t6", k, 1'b0, (k >= 1 && k <= 8), (k < 9) ? 4'd1 : 4'd0,
                (k <= 13), (k == 14));
    end
    tick = 1'b1;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
